// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch PC sequencer: branch modes and FSM states.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_ABS  = 2'b00,
    BR_REL  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_mode_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// popping when empty leaves state alone. Both cases raise a one-cycle pulse.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    tos_q;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic             unf_q;

  // tos_q is the next write slot; the live top sits one below it
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tos_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      if (push_i) begin
        tos_q <= tos_q + 1'b1;
        if (count_q == (AW+1)'(DEPTH)) ovf_q <= 1'b1;
        else count_q <= count_q + 1'b1;
      end else if (pop_i) begin
        if (count_q != '0) begin
          tos_q   <= tos_q - 1'b1;
          count_q <= count_q - 1'b1;
        end else begin
          unf_q <= 1'b1;
        end
      end
    end
  end

  assign top_o       = mem_q[tos_q - 1'b1];
  assign empty_o     = (count_q == '0);
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator: BOOT/RUN/HALTED FSM, prioritised next-PC mux and a
// return-address stack for CALL/RET.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(4),
  parameter int unsigned     STEP      = 1,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            take_br,
  input  logic [1:0]      br_mode,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_is_empty;

  assign seq_pc = pc_q + XLEN'(STEP);
  assign rel_pc = pc_q + branch_addr;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN: begin
        if (trap_req) begin
          pc_d = TRAP_VEC;
        end else if (halt_req) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (enable) begin
          if (take_br) begin
            case (br_mode_e'(br_mode))
              BR_ABS:  pc_d = branch_addr;
              BR_REL:  pc_d = rel_pc;
              BR_CALL: begin
                pc_d     = rel_pc;
                ras_push = 1'b1;
              end
              BR_RET: begin
                ras_pop = 1'b1;
                pc_d    = ras_is_empty ? seq_pc : ras_top;
              end
              default: pc_d = seq_pc;
            endcase
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      ST_HALTED: begin
        if (trap_req) begin
          pc_d    = TRAP_VEC;
          state_d = ST_RUN;
          valid_d = 1'b1;
        end else if (resume) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  ras_stack #(
    .WIDTH(XLEN),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (reset_n),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .data_i     (seq_pc),
    .top_o      (ras_top),
    .empty_o    (ras_is_empty),
    .overflow_o (ras_overflow),
    .underflow_o(ras_underflow)
  );

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign ras_empty = ras_is_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        take_br = 1'b0;
  logic [1:0]  br_mode = 2'b00;
  logic [31:0] branch_addr = '0;
  logic        trap_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_overflow, ras_underflow;

  pc_sequencer #(
    .XLEN(32), .RESET_VEC(32'd0), .TRAP_VEC(32'd4), .STEP(1), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .take_br(take_br),
    .br_mode(br_mode), .branch_addr(branch_addr), .trap_req(trap_req),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_valid(pc_valid),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        empty;
    logic        ovf;
    logic        unf;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // reference model state: 0 boot, 1 run, 2 halted
  logic [31:0] m_pc;
  int unsigned m_st, m_cnt, m_wr;
  logic [31:0] m_ras [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_st = 0; m_cnt = 0; m_wr = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    obs_t e;
    logic [31:0] np;
    np = m_pc; e.ovf = 1'b0; e.unf = 1'b0;
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (trap_req) np = 32'd4;
      else if (halt_req) m_st = 2;
      else if (enable) begin
        if (!take_br) np = m_pc + 32'd1;
        else begin
          case (br_mode)
            2'd0: np = branch_addr;
            2'd1: np = m_pc + branch_addr;
            2'd2: begin
              m_ras[m_wr] = m_pc + 32'd1;
              m_wr = (m_wr + 1) % 4;
              if (m_cnt == 4) e.ovf = 1'b1; else m_cnt++;
              np = m_pc + branch_addr;
            end
            default: begin
              if (m_cnt == 0) begin
                e.unf = 1'b1; np = m_pc + 32'd1;
              end else begin
                m_wr = (m_wr + 3) % 4; np = m_ras[m_wr]; m_cnt--;
              end
            end
          endcase
        end
      end
    end else begin
      if (trap_req) begin np = 32'd4; m_st = 1; end
      else if (resume) m_st = 1;
    end
    m_pc = np;
    e.pc = np; e.valid = (m_st == 1); e.empty = (m_cnt == 0);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("pc", pc, e.pc);
      check_eq("pc_valid", pc_valid, e.valid);
      check_eq("ras_empty", ras_empty, e.empty);
      check_eq("ras_overflow", ras_overflow, e.ovf);
      check_eq("ras_underflow", ras_underflow, e.unf);
    end
  endtask

  task automatic idle();
    enable = 1'b1; take_br = 1'b0; trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic br(input logic [1:0] mode, input logic [31:0] addr);
    idle(); take_br = 1'b1; br_mode = mode; branch_addr = addr;
    cycle();
    take_br = 1'b0;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_valid", pc_valid, 1'b0);
    check_eq("rst_empty", ras_empty, 1'b1);
    check_eq("rst_ovf", ras_overflow, 1'b0);
    check_eq("rst_unf", ras_underflow, 1'b0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    #12;
    check_eq("por_pc", pc, 32'd0);
    check_eq("por_valid", pc_valid, 1'b0);
    check_eq("por_empty", ras_empty, 1'b1);
    reset_n = 1'b1;

    // 1: boot then sequential counting, then async reset mid-run
    cycle();
    check_eq("boot_pc", pc, 32'd0);
    check_eq("boot_valid", pc_valid, 1'b1);
    repeat (3) cycle();
    check_eq("seq_pc3", pc, 32'd3);
    async_reset();
    cycle();
    repeat (10) cycle();
    check_eq("at_10", pc, 32'd10);

    // 2: ABS and negative REL
    br(2'd0, 32'd3);
    check_eq("abs_3", pc, 32'd3);
    cycle();
    check_eq("after_abs", pc, 32'd4);
    br(2'd1, 32'hFFFF_FFFE);
    check_eq("rel_neg", pc, 32'd2);

    // 3: CALL / RET pair
    repeat (3) cycle();
    br(2'd2, 32'd20);
    check_eq("call_pc", pc, 32'd25);
    check_eq("call_nonempty", ras_empty, 1'b0);
    br(2'd3, 32'hDEAD_BEEF);
    check_eq("ret_pc", pc, 32'd6);
    check_eq("ret_empty", ras_empty, 1'b1);

    // 4: five nested calls overflow, five returns underflow
    for (int i = 0; i < 5; i++) br(2'd2, 32'd10);
    check_eq("ovf_pulse", ras_overflow, 1'b1);
    check_eq("call5_pc", pc, 32'd56);
    br(2'd3, '0);
    check_eq("ovf_cleared", ras_overflow, 1'b0);
    check_eq("ret1", pc, 32'd47);
    br(2'd3, '0); check_eq("ret2", pc, 32'd37);
    br(2'd3, '0); check_eq("ret3", pc, 32'd27);
    br(2'd3, '0); check_eq("ret4", pc, 32'd17);
    br(2'd3, '0);
    check_eq("ret5_seq", pc, 32'd18);
    check_eq("unf_pulse", ras_underflow, 1'b1);
    cycle();
    check_eq("unf_cleared", ras_underflow, 1'b0);

    // wrap at 2^32
    br(2'd0, 32'hFFFF_FFFF);
    cycle();
    check_eq("wrap", pc, 32'd0);

    // 5: stall drops branch, trap ignores enable
    async_reset();
    cycle();
    repeat (7) cycle();
    enable = 1'b0; take_br = 1'b1; br_mode = 2'd0; branch_addr = 32'd3;
    cycle();
    check_eq("stall_hold", pc, 32'd7);
    take_br = 1'b0;
    cycle();
    check_eq("stall_drop", pc, 32'd7);
    trap_req = 1'b1;
    cycle();
    check_eq("trap_stalled", pc, 32'd4);

    // 6: halt, hold, resume; halt then trap
    idle();
    repeat (5) cycle();
    halt_req = 1'b1;
    cycle();
    check_eq("halt_pc", pc, 32'd9);
    check_eq("halt_valid", pc_valid, 1'b0);
    halt_req = 1'b0;
    repeat (5) cycle();
    check_eq("halt_hold", pc, 32'd9);
    resume = 1'b1;
    cycle();
    check_eq("resume_valid", pc_valid, 1'b1);
    check_eq("resume_pc", pc, 32'd9);
    resume = 1'b0;
    cycle();
    check_eq("resume_next", pc, 32'd10);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    cycle();
    trap_req = 1'b1;
    cycle();
    check_eq("halt_trap_pc", pc, 32'd4);
    check_eq("halt_trap_valid", pc_valid, 1'b1);
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
